// File: rtl/bp_cache_assoc_pkg.sv
// Shared definitions for the set-associative branch-prediction cache:
// geometry helpers and the write-action classification.
package bp_cache_assoc_pkg;

   typedef enum logic [1:0] {
      WR_NONE,
      WR_HIT,
      WR_FILL,
      WR_EVICT
   } wr_kind_t;

   function automatic int set_bits(input int lines, input int ways);
      return $clog2(lines / ways);
   endfunction

   // A direct-mapped build still carries a one-bit pointer so port widths never collapse to zero.
   function automatic int ptr_bits(input int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

endpackage

// File: rtl/bp_cache_assoc_lookup.sv
// One lookup port: tag compare across the ways of the addressed set, way mux,
// and same-cycle forwarding of an exact-address write.
module bp_cache_assoc_lookup #(
   parameter int AWIDTH   = 32,
   parameter int DWIDTH   = 32,
   parameter int WAYS     = 2,
   parameter int TAG_BITS = 26
) (
   input  logic                     reset,
   input  logic [AWIDTH-1:0]        addr,
   input  logic [TAG_BITS-1:0]      tag,
   input  logic [WAYS-1:0]          set_valid,
   input  logic [WAYS*TAG_BITS-1:0] set_tags,
   input  logic [WAYS*DWIDTH-1:0]   set_data,
   input  logic                     we,
   input  logic [AWIDTH-1:0]        wa,
   input  logic [DWIDTH-1:0]        din,
   output logic                     hit,
   output logic [DWIDTH-1:0]        dout
);

   // NOTE: every output gets a default before any condition, so no latch is inferred.
   always_comb begin
      hit  = 1'b0;
      dout = '0;
      if (!reset) begin
         for (int k = 0; k < WAYS; k++) begin
            if (set_valid[k] && set_tags[k*TAG_BITS +: TAG_BITS] == tag) begin
               hit  = 1'b1;
               dout = set_data[k*DWIDTH +: DWIDTH];
            end
         end
         // Only a full-address match forwards; a same-set write to another tag is invisible until it lands.
         if (we && addr == wa) begin
            hit  = 1'b1;
            dout = din;
         end
      end
   end

endmodule

// File: rtl/bp_cache_assoc.sv
// N-way set-associative branch-prediction cache: NUM_RD combinational lookups,
// one write/fill port with round-robin eviction, one single-entry invalidate port.
module bp_cache_assoc
   import bp_cache_assoc_pkg::*;
#(
   parameter int AWIDTH = 32,
   parameter int DWIDTH = 32,
   parameter int LINES  = 128,
   parameter int WAYS   = 2,
   parameter int NUM_RD = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD*AWIDTH-1:0] ra,
   output logic [NUM_RD*DWIDTH-1:0] dout,
   output logic [NUM_RD-1:0]        hit,
   input  logic                     we,
   input  logic [AWIDTH-1:0]        wa,
   input  logic [DWIDTH-1:0]        din,
   input  logic                     inv,
   input  logic [AWIDTH-1:0]        inva
);

   localparam int SETS     = LINES / WAYS;
   localparam int SET_BITS = set_bits(LINES, WAYS);
   localparam int IDX_W    = (SET_BITS > 0) ? SET_BITS : 1;
   localparam int TAG_BITS = AWIDTH - SET_BITS;
   localparam int PTR_BITS = ptr_bits(WAYS);

   function automatic logic [IDX_W-1:0] idx_of(input logic [AWIDTH-1:0] a);
      return IDX_W'(a & AWIDTH'(SETS - 1));
   endfunction

   function automatic logic [TAG_BITS-1:0] tag_of(input logic [AWIDTH-1:0] a);
      return TAG_BITS'(a >> SET_BITS);
   endfunction

   logic [WAYS-1:0]     valid_q [SETS];
   logic [TAG_BITS-1:0] tag_q   [SETS][WAYS];
   logic [DWIDTH-1:0]   data_q  [SETS][WAYS];
   logic [PTR_BITS-1:0] ptr_q   [SETS];

   logic [IDX_W-1:0]    w_idx, i_idx;
   logic [TAG_BITS-1:0] w_tag, i_tag;
   logic [WAYS-1:0]     w_match, i_match;
   logic [PTR_BITS-1:0] w_way, i_way, ptr_next;
   logic                i_hit;
   wr_kind_t            w_kind;

   // All decisions are taken from pre-update state; lower way numbers win via the descending scans.
   always_comb begin
      w_idx  = idx_of(wa);
      w_tag  = tag_of(wa);
      i_idx  = idx_of(inva);
      i_tag  = tag_of(inva);
      w_kind = WR_NONE;
      w_way  = '0;
      i_hit  = 1'b0;
      i_way  = '0;
      for (int k = 0; k < WAYS; k++) begin
         w_match[k] = valid_q[w_idx][k] && (tag_q[w_idx][k] == w_tag);
         i_match[k] = valid_q[i_idx][k] && (tag_q[i_idx][k] == i_tag);
      end
      for (int k = WAYS - 1; k >= 0; k--) begin
         if (i_match[k]) begin
            i_hit = 1'b1;
            i_way = PTR_BITS'(k);
         end
      end
      if (we) begin
         if (|w_match) begin
            w_kind = WR_HIT;
            for (int k = WAYS - 1; k >= 0; k--)
               if (w_match[k]) w_way = PTR_BITS'(k);
         end else if (!(&valid_q[w_idx])) begin
            w_kind = WR_FILL;
            for (int k = WAYS - 1; k >= 0; k--)
               if (!valid_q[w_idx][k]) w_way = PTR_BITS'(k);
         end else begin
            w_kind = WR_EVICT;
            w_way  = ptr_q[w_idx];
         end
      end
      ptr_next = (ptr_q[w_idx] == PTR_BITS'(WAYS - 1)) ? '0 : ptr_q[w_idx] + 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments; the write's later assignment to the
   // same valid bit overrides the invalidate, which is exactly the write-wins rule.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            ptr_q[s]   <= '0;
         end
      end else begin
         if (inv && i_hit)
            valid_q[i_idx][i_way] <= 1'b0;
         if (w_kind != WR_NONE)
            valid_q[w_idx][w_way] <= 1'b1;
         if (w_kind == WR_EVICT)
            ptr_q[w_idx] <= ptr_next;
      end
   end

   // NOTE: tags and data are deliberately left out of reset; the valid bits alone qualify them.
   always_ff @(posedge clk) begin
      if (!reset && w_kind != WR_NONE) begin
         tag_q[w_idx][w_way]  <= w_tag;
         data_q[w_idx][w_way] <= din;
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [AWIDTH-1:0]        addr;
      logic [IDX_W-1:0]         idx;
      logic [TAG_BITS-1:0]      tag;
      logic [WAYS*TAG_BITS-1:0] set_tags;
      logic [WAYS*DWIDTH-1:0]   set_data;

      assign addr = ra[p*AWIDTH +: AWIDTH];
      assign idx  = idx_of(addr);
      assign tag  = tag_of(addr);

      always_comb begin
         for (int k = 0; k < WAYS; k++) begin
            set_tags[k*TAG_BITS +: TAG_BITS] = tag_q[idx][k];
            set_data[k*DWIDTH +: DWIDTH]     = data_q[idx][k];
         end
      end

      bp_cache_assoc_lookup #(
         .AWIDTH   (AWIDTH),
         .DWIDTH   (DWIDTH),
         .WAYS     (WAYS),
         .TAG_BITS (TAG_BITS)
      ) u_lookup (
         .reset     (reset),
         .addr      (addr),
         .tag       (tag),
         .set_valid (valid_q[idx]),
         .set_tags  (set_tags),
         .set_data  (set_data),
         .we        (we),
         .wa        (wa),
         .din       (din),
         .hit       (hit[p]),
         .dout      (dout[p*DWIDTH +: DWIDTH])
      );
   end

endmodule
